mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between instruction fetch (I port) and load/store (D port).

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch (I) and load/store (D).
// One transaction at a time, D-priority with a starvation guard for I, and an optional timeout.
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_done,
   output logic [XLEN-1:0]       i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [XLEN-1:0]       d_wdata,
   input  logic [XLEN/8-1:0]     d_be,
   output logic                  d_done,
   output logic [XLEN-1:0]       d_rdata,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [XLEN-1:0]       m_wdata,
   output logic [XLEN/8-1:0]     m_be,
   input  logic                  m_ready,
   input  logic [XLEN-1:0]       m_rdata,
   output logic                  err_timeout
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
   localparam logic          TIMEOUT_EN = (TIMEOUT > 0);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [XLEN-1:0]       m_wdata_q, m_wdata_d;
   logic [XLEN/8-1:0]     m_be_q, m_be_d;

   logic busy, expire, finish, grant_d, grant_i;

   assign busy    = (state_q != IDLE);
   assign expire  = busy & ~m_ready & TIMEOUT_EN & (timer_q == TIMER_LAST);
   assign finish  = busy & (m_ready | expire);
   // D wins ties unless it has already starved a waiting fetch for MAX_D_STREAK grants
   assign grant_d = d_req & (~i_req | (streak_q != STREAK_MAX));
   assign grant_i = i_req & ~grant_d;

   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      timer_d   = timer_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_be_d    = m_be_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d   = BUSY_D;
               timer_d   = '0;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_be_d    = d_be;
               if (!i_req)
                  streak_d = '0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + SW'(1);
            end else if (grant_i) begin
               state_d   = BUSY_I;
               timer_d   = '0;
               streak_d  = '0;
               m_we_d    = 1'b0;
               m_addr_d  = i_addr;
               m_wdata_d = '0;
               m_be_d    = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (finish) begin
               state_d   = IDLE;
               timer_d   = '0;
               m_we_d    = 1'b0;
               m_addr_d  = '0;
               m_wdata_d = '0;
               m_be_d    = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         timer_q   <= '0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         timer_q   <= timer_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_be_q    <= m_be_d;
      end
   end

   assign m_req       = busy;
   assign m_we        = m_we_q;
   assign m_addr      = m_addr_q;
   assign m_wdata     = m_wdata_q;
   assign m_be        = m_be_q;
   assign err_timeout = expire;

   // Read data only passes through on a real completion, never on a timeout abort
   assign i_done  = (state_q == BUSY_I) & finish;
   assign d_done  = (state_q == BUSY_D) & finish;
   assign i_rdata = ((state_q == BUSY_I) && m_ready) ? m_rdata : '0;
   assign d_rdata = ((state_q == BUSY_D) && m_ready) ? m_rdata : '0;

   assign stall_if  = reset & i_req & ~i_done;
   assign stall_mem = reset & d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 8;
   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic          clk, rstN;
   logic          iReq, iDone;
   logic [AW-1:0] iAddr;
   logic [31:0]   iRdata;
   logic          dReq, dWe, dDone;
   logic [AW-1:0] dAddr;
   logic [31:0]   dWdata, dRdata;
   logic [3:0]    dBe;
   logic          stallIf, stallMem;
   logic          mReq, mWeO, mReady, errTimeout;
   logic [AW-1:0] mAddrO;
   logic [31:0]   mWdataO, mRdata;
   logic [3:0]    mBeO;

   mem_port_arbiter #(
      .XLEN(XLEN), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(rstN),
      .i_req(iReq), .i_addr(iAddr), .i_done(iDone), .i_rdata(iRdata),
      .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_be(dBe),
      .d_done(dDone), .d_rdata(dRdata),
      .stall_if(stallIf), .stall_mem(stallMem),
      .m_req(mReq), .m_we(mWeO), .m_addr(mAddrO), .m_wdata(mWdataO), .m_be(mBeO),
      .m_ready(mReady), .m_rdata(mRdata), .err_timeout(errTimeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Reference model: the transaction currently owning the memory, if any
   bit            mBusy, mIsD;
   logic          mWe;
   logic [AW-1:0] mAddr;
   logic [31:0]   mWdata;
   logic [3:0]    mBe;
   int            mAge, mStreak;

   bit expIDone, expDDone;
   bit obsIDone, obsDDone, obsErr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mBusy   = 1'b0;
      mIsD    = 1'b0;
      mAge    = 0;
      mStreak = 0;
   endtask

   // Every output must be zero while reset is asserted
   task automatic checkQuiet(input string tag);
      check({tag, ".m_req"},     64'(mReq),       64'(0));
      check({tag, ".m_we"},      64'(mWeO),       64'(0));
      check({tag, ".m_addr"},    64'(mAddrO),     64'(0));
      check({tag, ".m_wdata"},   64'(mWdataO),    64'(0));
      check({tag, ".m_be"},      64'(mBeO),       64'(0));
      check({tag, ".i_done"},    64'(iDone),      64'(0));
      check({tag, ".i_rdata"},   64'(iRdata),     64'(0));
      check({tag, ".d_done"},    64'(dDone),      64'(0));
      check({tag, ".d_rdata"},   64'(dRdata),     64'(0));
      check({tag, ".err"},       64'(errTimeout), 64'(0));
      check({tag, ".stall_if"},  64'(stallIf),    64'(0));
      check({tag, ".stall_mem"}, 64'(stallMem),   64'(0));
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge
   task automatic cycleCheck();
      logic          eID, eDD, eErr, eMReq, eMWe;
      logic [31:0]   eIR, eDR, eMW;
      logic [AW-1:0] eMA;
      logic [3:0]    eMB;
      bit            fin, gD, gI;
      #1;
      eID = 0; eDD = 0; eErr = 0; eMReq = 0; eMWe = 0;
      eIR = '0; eDR = '0; eMW = '0; eMA = '0; eMB = '0;
      fin = 0;
      if (mBusy) begin
         eMReq = 1; eMWe = mWe; eMA = mAddr; eMW = mWdata; eMB = mBe;
         if (mReady) fin = 1;
         else if (mAge == TO - 1) begin
            fin  = 1;
            eErr = 1;
         end
         if (fin && mIsD) begin
            eDD = 1;
            if (mReady) eDR = mRdata;
         end else if (fin) begin
            eID = 1;
            if (mReady) eIR = mRdata;
         end
      end
      check("m_req",     64'(mReq),       64'(eMReq));
      check("m_we",      64'(mWeO),       64'(eMWe));
      check("m_addr",    64'(mAddrO),     64'(eMA));
      check("m_wdata",   64'(mWdataO),    64'(eMW));
      check("m_be",      64'(mBeO),       64'(eMB));
      check("i_done",    64'(iDone),      64'(eID));
      check("i_rdata",   64'(iRdata),     64'(eIR));
      check("d_done",    64'(dDone),      64'(eDD));
      check("d_rdata",   64'(dRdata),     64'(eDR));
      check("err",       64'(errTimeout), 64'(eErr));
      check("stall_if",  64'(stallIf),    64'(iReq & ~eID));
      check("stall_mem", 64'(stallMem),   64'(dReq & ~eDD));
      expIDone = eID;
      expDDone = eDD;
      obsIDone = iDone;
      obsDDone = dDone;
      obsErr   = errTimeout;
      gD = !mBusy && dReq && (!iReq || mStreak < MAXS);
      gI = !mBusy && iReq && !gD;
      @(posedge clk);
      if (mBusy) begin
         if (fin) mBusy = 0;
         else mAge++;
      end else if (gD) begin
         mBusy = 1; mIsD = 1; mAge = 0;
         mWe = dWe; mAddr = dAddr; mWdata = dWdata; mBe = dBe;
         mStreak = iReq ? ((mStreak < MAXS) ? mStreak + 1 : MAXS) : 0;
      end else if (gI) begin
         mBusy = 1; mIsD = 0; mAge = 0;
         mWe = 0; mAddr = iAddr; mWdata = '0; mBe = '0;
         mStreak = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      int seqVal, seqLen, doneAt;
      bit errSeen;
      rstN = 1'b1;
      iReq = 0; iAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWdata = '0; dBe = '0;
      mReady = 0; mRdata = '0;
      expIDone = 0; expDDone = 0;
      resetModel();
      #1 rstN = 1'b0;
      #1 checkQuiet("reset");
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] test 1: lone fetch");
      iReq = 1; iAddr = 8'h10;
      cycleCheck();
      mReady = 1; mRdata = 32'h1234_5678;
      cycleCheck();
      check("t1.i_done", 64'(obsIDone), 64'(1));
      iReq = 0; mReady = 0;
      cycleCheck();

      $display("[TB] test 2: simultaneous store and fetch");
      iReq = 1; iAddr = 8'h30;
      dReq = 1; dWe = 1; dAddr = 8'h20; dWdata = 32'hDEAD_BEEF; dBe = 4'hF;
      mReady = 1; mRdata = 32'hA5A5_A5A5;
      cycleCheck();
      cycleCheck();
      check("t2.d_first", 64'(obsDDone), 64'(1));
      dReq = 0; dWe = 0;
      cycleCheck();
      mRdata = 32'h0BAD_F00D;
      cycleCheck();
      check("t2.i_second", 64'(obsIDone), 64'(1));
      iReq = 0; mReady = 0;

      $display("[TB] test 3: D streak limit");
      seqVal = 0; seqLen = 0;
      iReq = 1; iAddr = 8'h44; dReq = 1; dWe = 0; dAddr = 8'h48; mReady = 1;
      for (int c = 0; c < 10; c++) begin
         mRdata = $urandom;
         cycleCheck();
         if (obsDDone) begin seqVal = seqVal * 2 + 1; seqLen++; end
         if (obsIDone) begin seqVal = seqVal * 2; seqLen++; iReq = 0; end
      end
      check("t3.order", 64'(seqVal), 64'(5'b11110));
      check("t3.count", 64'(seqLen), 64'(5));
      dReq = 0; mReady = 0;
      cycleCheck();

      $display("[TB] test 4: timeout");
      dReq = 1; dWe = 0; dAddr = 8'h55; doneAt = 0; errSeen = 0;
      for (int c = 1; c <= 12; c++) begin
         cycleCheck();
         if (obsDDone && doneAt == 0) begin doneAt = c; errSeen = obsErr; dReq = 0; end
      end
      check("t4.done_cycle", 64'(doneAt), 64'(9));
      check("t4.err", 64'(errSeen), 64'(1));

      $display("[TB] test 6: ready on expiry cycle");
      dReq = 1; dAddr = 8'h66; doneAt = 0; errSeen = 1;
      for (int c = 1; c <= 12; c++) begin
         mReady = (c == 9);
         mRdata = 32'h6666_0000 + 32'(c);
         cycleCheck();
         if (obsDDone && doneAt == 0) begin doneAt = c; errSeen = obsErr; dReq = 0; end
      end
      check("t6.done_cycle", 64'(doneAt), 64'(9));
      check("t6.err", 64'(errSeen), 64'(0));
      mReady = 0;

      $display("[TB] test 5: async reset mid-transaction");
      dReq = 1; dWe = 1; dAddr = 8'h77; dWdata = 32'hCAFE_F00D; dBe = 4'h3;
      iReq = 1; iAddr = 8'h78;
      cycleCheck();
      cycleCheck();
      check("t5.busy", 64'(mReq), 64'(1));
      #3 rstN = 1'b0;
      #1 checkQuiet("t5.async");
      resetModel();
      @(posedge clk);
      @(negedge clk);
      checkQuiet("t5.held");
      rstN = 1'b1;
      cycleCheck();
      mReady = 1; mRdata = 32'h5555_AAAA;
      cycleCheck();
      dReq = 0;
      cycleCheck();
      cycleCheck();
      iReq = 0; mReady = 0;
      cycleCheck();

      $display("[TB] random traffic");
      for (int n = 0; n < 1500; n++) begin
         if (!iReq || expIDone) begin
            iReq  = ($urandom_range(0, 2) != 0);
            iAddr = 8'($urandom);
         end
         if (!dReq || expDDone) begin
            dReq   = ($urandom_range(0, 2) != 0);
            dWe    = 1'($urandom);
            dAddr  = 8'($urandom);
            dWdata = $urandom;
            dBe    = 4'($urandom);
         end
         mReady = ($urandom_range(0, 9) < 3);
         mRdata = $urandom;
         cycleCheck();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
